// File: rtl/pc_fetch_seq_pkg.sv
// Shared definitions for the instruction-fetch sequencer: default widths and
// the fetch state encoding.
package pc_fetch_seq_pkg;

    localparam int RW_DEF = 16;
    localparam int IW_DEF = 32;

    typedef enum logic [1:0] {
        FS_REQ  = 2'd0,
        FS_WAIT = 2'd1,
        FS_HOLD = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/pc_fetch_seq.sv
// Instruction-fetch sequencer: issues one memory read per PC value, holds the
// fetched word for decode, and arbitrates irq > jump > sequential advance.
module pc_fetch_seq
    import pc_fetch_seq_pkg::*;
#(
    parameter int RW = RW_DEF,
    parameter int IW = IW_DEF
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic [RW-1:0] i_pc,
    input  logic          i_pc_ovf,
    output logic          o_c_pc_inc,
    output logic          o_c_pc_ie,
    output logic          o_c_pc_irq,
    output logic          o_mem_req,
    input  logic          i_mem_ack,
    input  logic [IW-1:0] i_mem_data,
    output logic [IW-1:0] o_instr,
    output logic          o_instr_valid,
    input  logic          i_instr_ready,
    input  logic          i_jmp,
    output logic          o_jmp_ack,
    input  logic          i_irq,
    input  logic          i_irq_en,
    output logic          o_irq_ack,
    output logic [RW-1:0] o_epc,
    output logic          o_page_inc
);

    fetch_state_e  r_state;
    fetch_state_e  w_next_state;
    logic          r_jmp_pend;
    logic          w_jmp_pend_nxt;
    logic [IW-1:0] r_instr;
    logic          r_instr_valid;
    logic [RW-1:0] r_epc;
    logic          r_page_inc;

    logic          w_inc;
    logic          w_ie;
    logic          w_irq;
    logic          w_mem_req;
    logic          w_load_instr;
    logic          w_clr_valid;
    logic          w_epc_cap;

    // Next-state and strobe decode for the three fetch states.
    always_comb begin
        w_next_state   = r_state;
        w_jmp_pend_nxt = r_jmp_pend;
        w_inc          = 1'b0;
        w_ie           = 1'b0;
        w_irq          = 1'b0;
        w_mem_req      = 1'b0;
        w_load_instr   = 1'b0;
        w_clr_valid    = 1'b0;
        w_epc_cap      = 1'b0;
        case (r_state)
            FS_REQ: begin
                if (i_irq & i_irq_en) begin
                    w_irq     = 1'b1;
                    w_epc_cap = 1'b1;
                end else if (i_jmp) begin
                    w_ie = 1'b1;
                end else begin
                    w_mem_req    = 1'b1;
                    w_next_state = FS_WAIT;
                end
            end
            FS_WAIT: begin
                w_mem_req = 1'b1;
                if (i_mem_ack) begin
                    // A jump seen at any point of the read discards the word.
                    if (r_jmp_pend | i_jmp) begin
                        w_ie           = 1'b1;
                        w_jmp_pend_nxt = 1'b0;
                        w_next_state   = FS_REQ;
                    end else begin
                        w_inc        = 1'b1;
                        w_load_instr = 1'b1;
                        w_next_state = FS_HOLD;
                    end
                end else if (i_jmp) begin
                    w_jmp_pend_nxt = 1'b1;
                end else begin
                    w_jmp_pend_nxt = r_jmp_pend;
                end
            end
            FS_HOLD: begin
                if (i_jmp) begin
                    w_ie         = 1'b1;
                    w_clr_valid  = 1'b1;
                    w_next_state = FS_REQ;
                end else if (i_instr_ready) begin
                    w_clr_valid  = 1'b1;
                    w_next_state = FS_REQ;
                end else begin
                    w_next_state = FS_HOLD;
                end
            end
            default: begin
                w_jmp_pend_nxt = 1'b0;
                w_clr_valid    = 1'b1;
                w_next_state   = FS_REQ;
            end
        endcase
    end

    // Fetch state register and deferred-jump flag.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= FS_REQ;
            r_jmp_pend <= 1'b0;
        end else begin
            r_state    <= w_next_state;
            r_jmp_pend <= w_jmp_pend_nxt;
        end
    end

    // Held instruction, its valid flag, return PC and page-crossing pulse.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_instr       <= {IW{1'b0}};
            r_instr_valid <= 1'b0;
            r_epc         <= {RW{1'b0}};
            r_page_inc    <= 1'b0;
        end else begin
            if (w_load_instr) begin
                r_instr       <= i_mem_data;
                r_instr_valid <= 1'b1;
            end else if (w_clr_valid) begin
                r_instr_valid <= 1'b0;
            end else begin
                r_instr_valid <= r_instr_valid;
            end
            if (w_epc_cap) begin
                r_epc <= i_pc;
            end else begin
                r_epc <= r_epc;
            end
            r_page_inc <= w_inc & i_pc_ovf;
        end
    end

    // Combinational strobes are forced low while reset is asserted so a
    // read in flight is dropped at once.
    assign o_c_pc_inc    = w_inc & i_rst_n;
    assign o_c_pc_ie     = w_ie & i_rst_n;
    assign o_c_pc_irq    = w_irq & i_rst_n;
    assign o_jmp_ack     = w_ie & i_rst_n;
    assign o_irq_ack     = w_irq & i_rst_n;
    assign o_mem_req     = w_mem_req & i_rst_n;
    assign o_instr       = r_instr;
    assign o_instr_valid = r_instr_valid;
    assign o_epc         = r_epc;
    assign o_page_inc    = r_page_inc;

endmodule

// File: tb/tb_pc_fetch_seq.sv
// Directed self-checking bench for pc_fetch_seq: inputs change 1 time unit
// after the rising edge, outputs are compared on the falling edge.
module tb_pc_fetch_seq;

    localparam int RW = 16;
    localparam int IW = 32;

    logic          i_clk = 1'b0;
    logic          i_rst_n;
    logic [RW-1:0] i_pc;
    logic          i_pc_ovf;
    logic          o_c_pc_inc;
    logic          o_c_pc_ie;
    logic          o_c_pc_irq;
    logic          o_mem_req;
    logic          i_mem_ack;
    logic [IW-1:0] i_mem_data;
    logic [IW-1:0] o_instr;
    logic          o_instr_valid;
    logic          i_instr_ready;
    logic          i_jmp;
    logic          o_jmp_ack;
    logic          i_irq;
    logic          i_irq_en;
    logic          o_irq_ack;
    logic [RW-1:0] o_epc;
    logic          o_page_inc;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 i_clk = ~i_clk;

    pc_fetch_seq #(.RW(RW), .IW(IW)) u_dut (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_pc         (i_pc),
        .i_pc_ovf     (i_pc_ovf),
        .o_c_pc_inc   (o_c_pc_inc),
        .o_c_pc_ie    (o_c_pc_ie),
        .o_c_pc_irq   (o_c_pc_irq),
        .o_mem_req    (o_mem_req),
        .i_mem_ack    (i_mem_ack),
        .i_mem_data   (i_mem_data),
        .o_instr      (o_instr),
        .o_instr_valid(o_instr_valid),
        .i_instr_ready(i_instr_ready),
        .i_jmp        (i_jmp),
        .o_jmp_ack    (o_jmp_ack),
        .i_irq        (i_irq),
        .i_irq_en     (i_irq_en),
        .o_irq_ack    (o_irq_ack),
        .o_epc        (o_epc),
        .o_page_inc   (o_page_inc)
    );

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic mid();
        @(negedge i_clk);
    endtask

    task automatic next_cyc();
        @(posedge i_clk);
        #1;
    endtask

    // strobes packed as {inc, ie, irq}
    function automatic logic [2:0] strobes();
        return {o_c_pc_inc, o_c_pc_ie, o_c_pc_irq};
    endfunction

    initial begin
        i_rst_n = 1'b0; i_pc = 16'h0010; i_pc_ovf = 1'b0; i_mem_ack = 1'b0;
        i_mem_data = 32'h0000_0000; i_instr_ready = 1'b0; i_jmp = 1'b0;
        i_irq = 1'b0; i_irq_en = 1'b0;

        // reset values
        mid();
        check_eq("rst_strobes", 64'(strobes()), 64'h0);
        check_eq("rst_mem_req", 64'(o_mem_req), 64'h0);
        check_eq("rst_valid", 64'(o_instr_valid), 64'h0);
        check_eq("rst_instr", 64'(o_instr), 64'h0);
        check_eq("rst_epc", 64'(o_epc), 64'h0);
        check_eq("rst_page_inc", 64'(o_page_inc), 64'h0);
        check_eq("rst_acks", 64'({o_jmp_ack, o_irq_ack}), 64'h0);
        next_cyc();
        i_rst_n = 1'b1;

        // basic fetch, ack two cycles after request, ready=1
        mid();
        check_eq("t1_req", 64'(o_mem_req), 64'h1);
        check_eq("t1_req_strobes", 64'(strobes()), 64'h0);
        next_cyc();
        mid();
        check_eq("t1_wait_req", 64'(o_mem_req), 64'h1);
        check_eq("t1_wait_strobes", 64'(strobes()), 64'h0);
        next_cyc();
        i_mem_ack = 1'b1; i_mem_data = 32'hDEAD_BEEF;
        mid();
        check_eq("t1_ack_strobes", 64'(strobes()), 64'h4);
        check_eq("t1_ack_valid", 64'(o_instr_valid), 64'h0);
        next_cyc();
        i_mem_ack = 1'b0; i_mem_data = 32'h0; i_instr_ready = 1'b1;
        mid();
        check_eq("t1_hold_valid", 64'(o_instr_valid), 64'h1);
        check_eq("t1_hold_instr", 64'(o_instr), 64'hDEAD_BEEF);
        check_eq("t1_hold_strobes", 64'(strobes()), 64'h0);
        check_eq("t1_hold_mem_req", 64'(o_mem_req), 64'h0);
        next_cyc();
        i_instr_ready = 1'b0;
        mid();
        check_eq("t1_req_valid", 64'(o_instr_valid), 64'h0);
        check_eq("t1_back_req", 64'(o_mem_req), 64'h1);
        next_cyc();

        // HOLD stalled by decode for five cycles
        i_mem_ack = 1'b1; i_mem_data = 32'h1234_5678;
        mid();
        check_eq("t2_ack_strobes", 64'(strobes()), 64'h4);
        next_cyc();
        i_mem_ack = 1'b0; i_mem_data = 32'h0;
        for (int i = 0; i < 5; i++) begin
            mid();
            check_eq("t2_stall_valid", 64'(o_instr_valid), 64'h1);
            check_eq("t2_stall_instr", 64'(o_instr), 64'h1234_5678);
            check_eq("t2_stall_strobes", 64'(strobes()), 64'h0);
            check_eq("t2_stall_mem_req", 64'(o_mem_req), 64'h0);
            next_cyc();
        end
        i_instr_ready = 1'b1;
        mid();
        check_eq("t2_accept_valid", 64'(o_instr_valid), 64'h1);
        next_cyc();
        i_instr_ready = 1'b0;
        mid();
        check_eq("t2_req_valid", 64'(o_instr_valid), 64'h0);
        check_eq("t2_req_mem_req", 64'(o_mem_req), 64'h1);
        next_cyc();

        // jump during WAIT discards the fetched word
        i_jmp = 1'b1;
        mid();
        check_eq("t3_wait_jmp_strobes", 64'(strobes()), 64'h0);
        check_eq("t3_wait_jmp_ack", 64'(o_jmp_ack), 64'h0);
        check_eq("t3_wait_jmp_req", 64'(o_mem_req), 64'h1);
        next_cyc();
        i_jmp = 1'b0;
        mid();
        check_eq("t3_wait2_strobes", 64'(strobes()), 64'h0);
        next_cyc();
        i_mem_ack = 1'b1; i_mem_data = 32'hAAAA_5555;
        mid();
        check_eq("t3_ack_strobes", 64'(strobes()), 64'h2);
        check_eq("t3_ack_jmp_ack", 64'(o_jmp_ack), 64'h1);
        next_cyc();
        i_mem_ack = 1'b0; i_mem_data = 32'h0;
        mid();
        check_eq("t3_req_valid", 64'(o_instr_valid), 64'h0);
        check_eq("t3_instr_kept", 64'(o_instr), 64'h1234_5678);
        check_eq("t3_req_strobes", 64'(strobes()), 64'h0);
        check_eq("t3_req_mem_req", 64'(o_mem_req), 64'h1);
        next_cyc();

        // interrupt deferred while HOLD, taken in REQ
        i_mem_ack = 1'b1; i_mem_data = 32'hC0DE_0041;
        mid();
        check_eq("t4_ack_strobes", 64'(strobes()), 64'h4);
        next_cyc();
        i_mem_ack = 1'b0; i_irq = 1'b1; i_irq_en = 1'b1; i_pc = 16'h0041;
        for (int i = 0; i < 2; i++) begin
            mid();
            check_eq("t4_hold_strobes", 64'(strobes()), 64'h0);
            check_eq("t4_hold_irq_ack", 64'(o_irq_ack), 64'h0);
            check_eq("t4_hold_valid", 64'(o_instr_valid), 64'h1);
            next_cyc();
        end
        i_instr_ready = 1'b1;
        mid();
        check_eq("t4_accept_strobes", 64'(strobes()), 64'h0);
        next_cyc();
        i_instr_ready = 1'b0;
        mid();
        check_eq("t4_irq_strobes", 64'(strobes()), 64'h1);
        check_eq("t4_irq_ack", 64'(o_irq_ack), 64'h1);
        check_eq("t4_irq_no_req", 64'(o_mem_req), 64'h0);
        next_cyc();
        i_irq_en = 1'b0;
        mid();
        check_eq("t4_epc", 64'(o_epc), 64'h0041);
        check_eq("t4_irq_dis_strobes", 64'(strobes()), 64'h0);
        check_eq("t4_irq_dis_req", 64'(o_mem_req), 64'h1);
        next_cyc();
        i_irq_en = 1'b1; i_mem_ack = 1'b1; i_mem_data = 32'h3333_0000;
        mid();
        check_eq("t4_wait_irq_strobes", 64'(strobes()), 64'h4);
        check_eq("t4_wait_irq_ack", 64'(o_irq_ack), 64'h0);
        next_cyc();
        i_mem_ack = 1'b0; i_irq = 1'b0; i_instr_ready = 1'b1;
        mid();
        check_eq("t4_hold2_instr", 64'(o_instr), 64'h3333_0000);
        next_cyc();
        i_instr_ready = 1'b0;

        // irq and jmp together in REQ, then page overflow on increment
        i_irq = 1'b1; i_jmp = 1'b1; i_pc = 16'h0100;
        mid();
        check_eq("t5_both_strobes", 64'(strobes()), 64'h1);
        check_eq("t5_both_jmp_ack", 64'(o_jmp_ack), 64'h0);
        next_cyc();
        i_irq = 1'b0;
        mid();
        check_eq("t5_epc", 64'(o_epc), 64'h0100);
        check_eq("t5_jmp_strobes", 64'(strobes()), 64'h2);
        check_eq("t5_jmp_ack", 64'(o_jmp_ack), 64'h1);
        check_eq("t5_jmp_no_req", 64'(o_mem_req), 64'h0);
        next_cyc();
        i_jmp = 1'b0;
        mid();
        check_eq("t5_req", 64'(o_mem_req), 64'h1);
        next_cyc();
        i_mem_ack = 1'b1; i_mem_data = 32'h5A5A_A5A5; i_pc_ovf = 1'b1;
        mid();
        check_eq("t5_ovf_strobes", 64'(strobes()), 64'h4);
        check_eq("t5_page_before", 64'(o_page_inc), 64'h0);
        next_cyc();
        i_mem_ack = 1'b0; i_pc_ovf = 1'b0; i_jmp = 1'b1; i_instr_ready = 1'b1;
        mid();
        check_eq("t5_page_pulse", 64'(o_page_inc), 64'h1);
        check_eq("t5_hold_jmp_strobes", 64'(strobes()), 64'h2);
        check_eq("t5_hold_jmp_ack", 64'(o_jmp_ack), 64'h1);
        next_cyc();
        i_jmp = 1'b0; i_instr_ready = 1'b0; i_pc_ovf = 1'b1;
        mid();
        check_eq("t5_page_end", 64'(o_page_inc), 64'h0);
        check_eq("t5_flush_valid", 64'(o_instr_valid), 64'h0);
        check_eq("t5_flush_req", 64'(o_mem_req), 64'h1);
        next_cyc();
        i_pc_ovf = 1'b0;
        mid();
        check_eq("t5_ovf_no_inc", 64'(o_page_inc), 64'h0);
        check_eq("t5_wait_req", 64'(o_mem_req), 64'h1);
        next_cyc();

        // async reset in the middle of WAIT, then a late ack
        i_rst_n = 1'b0; i_mem_ack = 1'b1; i_mem_data = 32'hFFFF_FFFF;
        mid();
        check_eq("t6_rst_strobes", 64'(strobes()), 64'h0);
        check_eq("t6_rst_mem_req", 64'(o_mem_req), 64'h0);
        check_eq("t6_rst_valid", 64'(o_instr_valid), 64'h0);
        check_eq("t6_rst_instr", 64'(o_instr), 64'h0);
        check_eq("t6_rst_epc", 64'(o_epc), 64'h0);
        check_eq("t6_rst_page_inc", 64'(o_page_inc), 64'h0);
        next_cyc();
        i_rst_n = 1'b1;
        mid();
        check_eq("t6_late_ack_strobes", 64'(strobes()), 64'h0);
        check_eq("t6_late_ack_valid", 64'(o_instr_valid), 64'h0);
        check_eq("t6_late_ack_req", 64'(o_mem_req), 64'h1);
        next_cyc();
        i_mem_ack = 1'b0;
        mid();
        check_eq("t6_wait_valid", 64'(o_instr_valid), 64'h0);
        check_eq("t6_wait_strobes", 64'(strobes()), 64'h0);
        check_eq("t6_wait_req", 64'(o_mem_req), 64'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
